// File: rtl/pra_pkg.sv
// pra_pkg: sizing helpers shared by pipelined_ripple_adder and its chunks.
package pra_pkg;
  function automatic int chunk_of(input int width, input int stages);
    return width / stages;
  endfunction
  function automatic bit legal_cfg(input int width, input int stages);
    return stages >= 1 && stages <= width && width % stages == 0;
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/rca_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple of full_adder cells; also exposes the carry into the MSB.
module rca_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_c,
  output logic [CHUNK-1:0] o_s,
  output logic             o_c,
  output logic             o_cm
);
  logic [CHUNK:0] w_c;
  assign w_c[0] = i_c;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (.i_a(i_a[i]), .i_b(i_b[i]), .i_c(w_c[i]), .o_s(o_s[i]), .o_c(w_c[i+1]));
  end
  assign o_c  = w_c[CHUNK];
  assign o_cm = w_c[CHUNK-1];
endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit add split into STAGES registered ripple chunks, valid/ready streamed.
// Define PRA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module pipelined_ripple_adder
  import pra_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PRA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int CHUNK = chunk_of(WIDTH, STAGES);
  if (!legal_cfg(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end
  logic [STAGES-1:0] r_vld, r_cy;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [STAGES-1:0] w_vi, w_ci, w_co, w_cm;
  logic [WIDTH-1:0]  w_ai [STAGES];
  logic [WIDTH-1:0]  w_bi [STAGES];
  logic [WIDTH-1:0]  w_si [STAGES];
  logic [WIDTH-1:0]  w_so [STAGES];
  logic [CHUNK-1:0]  w_s [STAGES];
  logic              w_adv, w_unused;
  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_cy[STAGES-1];
  // Operands travel right-shifted so every stage adds the low CHUNK bits of what it holds.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k == 0) begin : g_head
      assign w_vi[k] = in_valid;
      assign w_ci[k] = cin;
      assign w_ai[k] = a;
      assign w_bi[k] = b;
      assign w_si[k] = '0;
    end else begin : g_tail
      assign w_vi[k] = r_vld[k-1];
      assign w_ci[k] = r_cy[k-1];
      assign w_ai[k] = r_a[k-1];
      assign w_bi[k] = r_b[k-1];
      assign w_si[k] = r_sum[k-1];
    end
    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .i_a(w_ai[k][CHUNK-1:0]), .i_b(w_bi[k][CHUNK-1:0]), .i_c(w_ci[k]),
      .o_s(w_s[k]), .o_c(w_co[k]), .o_cm(w_cm[k])
    );
    assign w_so[k] = w_si[k] | (WIDTH'(w_s[k]) << (k * CHUNK));
  end
  assign w_unused = ^{w_cm, r_a[STAGES-1], r_b[STAGES-1]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_vld <= '0;
      r_cy  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_sum[i] <= '0;
      end
    end else if (w_adv) begin
      r_vld <= w_vi;
      r_cy  <= w_co;
      for (int i = 0; i < STAGES; i++) begin
        r_a[i]   <= w_ai[i] >> CHUNK;
        r_b[i]   <= w_bi[i] >> CHUNK;
        r_sum[i] <= w_so[i];
      end
    end
`ifdef PRA_OVERFLOW_EN
  logic r_ovf;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ovf <= 1'b0;
    else if (w_adv) r_ovf <= w_cm[STAGES-1] ^ w_co[STAGES-1];
  assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: scoreboard bench for the default 32-bit, 4-stage adder.
// Define PRA_OVERFLOW_EN for both RTL and bench to also check ovf.
module tb_pipelined_ripple_adder;
  localparam int S = 4;
  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          t;
    logic        lat;
  } exp_t;
  logic        clk, rst, in_valid, in_ready, cin, out_valid, out_ready, cout, run;
  logic [31:0] a, b, sum;
`ifdef PRA_OVERFLOW_EN
  logic        ovf;
`endif
  exp_t        q[$];
  exp_t        e;
  int          n_chk, n_pass, cyc;
  logic        lat_on, stalled, st_co;
  logic [31:0] st_sum;
  logic [32:0] tot;

  pipelined_ripple_adder #(.WIDTH(32), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef PRA_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  initial begin
    clk = 0;
    wait (run);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst) stalled = 0;
    else begin
      if (stalled) begin
        chk("hold_valid", 64'(out_valid), 1);
        chk("hold_sum", 64'(sum), 64'(st_sum));
        chk("hold_cout", 64'(cout), 64'(st_co));
      end
      stalled = out_valid && !out_ready;
      st_sum  = sum;
      st_co   = cout;
      if (out_valid && out_ready) begin
        chk("result_expected", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sum", 64'(sum), 64'(e.s));
          chk("cout", 64'(cout), 64'(e.co));
`ifdef PRA_OVERFLOW_EN
          chk("ovf", 64'(ovf), 64'(e.ov));
`endif
          if (e.lat) chk("latency", 64'(cyc - e.t), S);
        end
      end
      if (in_valid && in_ready) begin
        tot  = {1'b0, a} + {1'b0, b} + 33'(cin);
        e.s  = tot[31:0];
        e.co = tot[32];
        e.ov = (a[31] == b[31]) && (tot[31] != a[31]);
        e.t  = cyc;
        e.lat = lat_on;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
    logic ok;
    ok = 0;
    in_valid = 1; a = ta; b = tb; cin = tc;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_empty();
    out_ready = 1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drained", 64'(q.size()), 0);
  endtask

  initial begin
    run = 0; rst = 0; in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 1;
    n_chk = 0; n_pass = 0; cyc = 0; lat_on = 0; stalled = 0;
    #1 rst = 1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_sum", 64'(sum), 0);
    chk("rst_cout", 64'(cout), 0);
    run = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;
    lat_on = 1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 0);
    wait_empty();
    for (int i = 0; i < 8; i++) send(32'(i) * 32'h1111_1111, 32'h0F0F_0F0F, 1'(i & 1));
    wait_empty();
    lat_on = 0;
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(32'h8000_0000 + 32'(i), 32'h1234_5678 * 32'(i + 1), 1'(i));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 0);
    end
    @(posedge clk); #1;
    wait_empty();
    for (int i = 0; i < 3; i++) send(32'hDEAD_0000 + 32'(i), 32'h0000_BEEF, 1);
    #1 rst = 1;
    q.delete();
    #1 chk("mid_rst_out_valid", 64'(out_valid), 0);
    #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;
    lat_on = 1;
    send(32'hCAFE_F00D, 32'h3501_0FF3, 1);
    wait_empty();
    send(32'h7FFF_FFFF, 32'h0000_0001, 0);
    send(32'h8000_0000, 32'h8000_0000, 0);
    wait_empty();
    lat_on = 0;
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      b         = $urandom;
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 0;
    wait_empty();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
